fpdiv: RTL and testbench

- Sequential signed fixed-point divider. It is the inverse-operation companion to the team's fpmult block and shares its number format (P integer bits, Q fractional bits, two's complement), rounding-mode encoding and start/valid/ready handshake.
- Computes p = x / y with one restoring-division quotient bit per cycle, then rounds and saturates.
- Sits beside fpmult in the arithmetic datapath.

---
 rtl/fpdiv_pkg.sv | 23 ++
 rtl/fpdiv_round.sv | 63 ++++++
 rtl/fpdiv.sv | 141 ++++++++++++++
 tb/tb_fpdiv.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fixed-point divider (rounding modes match fpmult).
package fpdiv_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC   = 2'd0,
    RND_NEAREST = 2'd1,
    RND_POS_INF = 2'd2,
    RND_NEG_INF = 2'd3
  } round_mode_t;

  localparam int unsigned OOR_POS_OVF = 0;
  localparam int unsigned OOR_NEG_OVF = 1;
  localparam int unsigned OOR_DIV0    = 2;
  localparam int unsigned OOR_INEXACT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StFin,
    StDone
  } fpdiv_state_t;

endpackage

// File: rtl/fpdiv_round.sv
// Combinational rounding, sign application and saturation of an unsigned magnitude.
module fpdiv_round
  import fpdiv_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned MagW = 24
) (
  input  logic [MagW-1:0] mag,
  input  logic            r,
  input  logic            sticky,
  input  logic            sign,
  input  round_mode_t     mode,
  input  logic            div0,
  input  logic            x_neg,
  input  logic            x_zero,
  output logic [N-1:0]    result,
  output logic [3:0]      oor
);

  localparam logic [N-1:0]  MaxPos = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MinNeg = {1'b1, {(N-1){1'b0}}};
  localparam logic [MagW:0] LimPos = {{(MagW+2-N){1'b0}}, {(N-1){1'b1}}};
  localparam logic [MagW:0] LimNeg = LimPos + 1'b1;

  logic            inexact;
  logic            inc;
  logic [MagW:0]   mag_r;

  always_comb begin
    inexact = r | sticky;
    inc     = 1'b0;
    unique case (mode)
      RND_TRUNC:   inc = 1'b0;
      RND_NEAREST: inc = r;
      RND_POS_INF: inc = inexact & ~sign;
      RND_NEG_INF: inc = inexact & sign;
      default:     inc = 1'b0;
    endcase
    mag_r = {1'b0, mag} + {{MagW{1'b0}}, inc};
  end

  always_comb begin
    result = '0;
    oor    = '0;
    if (div0) begin
      // Divide by zero reports only the div0 flag; sign of x picks the rail.
      oor[OOR_DIV0] = 1'b1;
      result        = x_zero ? '0 : (x_neg ? MinNeg : MaxPos);
    end else begin
      oor[OOR_INEXACT] = inexact;
      if (!sign && (mag_r > LimPos)) begin
        result           = MaxPos;
        oor[OOR_POS_OVF] = 1'b1;
      end else if (sign && (mag_r > LimNeg)) begin
        result           = MinNeg;
        oor[OOR_NEG_OVF] = 1'b1;
      end else begin
        result = sign ? -mag_r[N-1:0] : mag_r[N-1:0];
      end
    end
  end

endmodule

// File: rtl/fpdiv.sv
// Sequential signed fixed-point divider: one restoring quotient bit per cycle, then round/saturate.
module fpdiv
  import fpdiv_pkg::*;
#(
  parameter int unsigned P = 8,
  parameter int unsigned Q = 8,
  localparam int unsigned N = P + Q
) (
  input  logic         clk_in,
  input  logic         rst_in_N,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  input  logic [1:0]   round_in,
  input  logic         start_in,
  output logic [N-1:0] p_out,
  output logic [3:0]   oor_out,
  output logic         valid_out,
  output logic         ready_out
);

  // Quotient carries one extra fractional bit that becomes the round bit.
  localparam int unsigned W    = N + Q + 1;
  localparam int unsigned CntW = $clog2(W + 1);

  fpdiv_state_t state_q, state_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    ay_q, ay_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            x_neg_q, x_neg_d;
  logic            x_zero_q, x_zero_d;
  round_mode_t     mode_q, mode_d;
  logic [N-1:0]    p_q, p_d;
  logic [3:0]      oor_q, oor_d;

  logic [N-1:0]    ax, ay;
  logic [N:0]      rem_sh, diff;
  logic            ge;
  logic [N-1:0]    rnd_result;
  logic [3:0]      rnd_oor;

  assign ax     = x_in[N-1] ? -x_in : x_in;
  assign ay     = y_in[N-1] ? -y_in : y_in;
  assign rem_sh = {rem_q, dvd_q[W-1]};
  assign diff   = rem_sh - {1'b0, ay_q};
  assign ge     = rem_sh >= {1'b0, ay_q};

  fpdiv_round #(
    .N    (N),
    .MagW (W - 1)
  ) u_round (
    .mag    (dvd_q[W-1:1]),
    .r      (dvd_q[0]),
    .sticky (|rem_q),
    .sign   (sign_q),
    .mode   (mode_q),
    .div0   (ay_q == '0),
    .x_neg  (x_neg_q),
    .x_zero (x_zero_q),
    .result (rnd_result),
    .oor    (rnd_oor)
  );

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    ay_d     = ay_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    x_neg_d  = x_neg_q;
    x_zero_d = x_zero_q;
    mode_d   = mode_q;
    p_d      = p_q;
    oor_d    = oor_q;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          sign_d   = x_in[N-1] ^ y_in[N-1];
          x_neg_d  = x_in[N-1];
          x_zero_d = (x_in == '0);
          ay_d     = ay;
          mode_d   = round_mode_t'(round_in);
          dvd_d    = {ax, {(Q+1){1'b0}}};
          rem_d    = '0;
          cnt_d    = CntW'(W);
          state_d  = StDiv;
        end
      end
      StDiv: begin
        // Quotient bits shift in behind the consumed dividend bits.
        rem_d = ge ? diff[N-1:0] : rem_sh[N-1:0];
        dvd_d = {dvd_q[W-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFin;
      end
      StFin: begin
        p_d     = rnd_result;
        oor_d   = rnd_oor;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_N) begin
    if (!rst_in_N) begin
      state_q  <= StIdle;
      dvd_q    <= '0;
      rem_q    <= '0;
      ay_q     <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      x_neg_q  <= 1'b0;
      x_zero_q <= 1'b0;
      mode_q   <= RND_TRUNC;
      p_q      <= '0;
      oor_q    <= '0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      ay_q     <= ay_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      x_neg_q  <= x_neg_d;
      x_zero_q <= x_zero_d;
      mode_q   <= mode_d;
      p_q      <= p_d;
      oor_q    <= oor_d;
    end
  end

  assign p_out     = p_q;
  assign oor_out   = oor_q;
  assign ready_out = (state_q == StIdle);
  assign valid_out = (state_q == StDone);

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: vector table through a scoreboard, plus handshake/reset sequences.
module tb_fpdiv;

  localparam int unsigned N = 16;
  localparam int unsigned Lat = 26;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] x_in, y_in;
  logic [1:0]   round_in;
  logic         start_in;
  logic [N-1:0] p_out;
  logic [3:0]   oor_out;
  logic         valid_out, ready_out;

  fpdiv #(
    .P (8),
    .Q (8)
  ) dut (
    .clk_in    (clk),
    .rst_in_N  (rst_n),
    .x_in      (x_in),
    .y_in      (y_in),
    .round_in  (round_in),
    .start_in  (start_in),
    .p_out     (p_out),
    .oor_out   (oor_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [1:0]   rnd;
    logic [N-1:0] p;
    logic [3:0]   oor;
  } vec_t;

  typedef struct {
    logic [N-1:0] p;
    logic [3:0]   oor;
    string        tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest accepted operation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && valid_out === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_p"}, {16'd0, p_out}, {16'd0, e.p});
        chk({e.tag, "_oor"}, {28'd0, oor_out}, {28'd0, e.oor});
      end
    end
  end

  task automatic do_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [1:0] rnd, input logic [N-1:0] ep, input logic [3:0] eo);
    int waitc = 0;
    int lat = 0;
    bit got = 0;
    bit ready_bad = 0;
    while (ready_out !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, "_ready_idle"}, {31'd0, ready_out}, 32'd1);
    x_in = x; y_in = y; round_in = rnd; start_in = 1'b1;
    @(posedge clk);
    sb.push_back('{ep, eo, tag});
    #1;
    start_in = 1'b0;
    x_in = ~x; y_in = 16'h0001; round_in = ~rnd;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (ready_out !== 1'b0) ready_bad = 1'b1;
      if (valid_out === 1'b1) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_latency"}, lat, Lat);
    chk({tag, "_ready_low"}, {31'd0, ready_bad}, 32'd0);
    if (!got && sb.size() > 0) void'(sb.pop_back());
    @(posedge clk); #1;
    chk({tag, "_valid_one_cycle"}, {31'd0, valid_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    bit got;
    vecs[0]  = '{16'h0180, 16'h0080, 2'b00, 16'h0300, 4'b0000};
    vecs[1]  = '{16'h0100, 16'h0300, 2'b00, 16'h0055, 4'b1000};
    vecs[2]  = '{16'h0100, 16'h0300, 2'b10, 16'h0056, 4'b1000};
    vecs[3]  = '{16'hFF00, 16'h0300, 2'b11, 16'hFFAA, 4'b1000};
    vecs[4]  = '{16'hFF00, 16'h0300, 2'b00, 16'hFFAB, 4'b1000};
    vecs[5]  = '{16'h0001, 16'h0200, 2'b01, 16'h0001, 4'b1000};
    vecs[6]  = '{16'h0001, 16'h0200, 2'b00, 16'h0000, 4'b1000};
    vecs[7]  = '{16'h7F00, 16'h0040, 2'b00, 16'h7FFF, 4'b0001};
    vecs[8]  = '{16'h8000, 16'hFF00, 2'b00, 16'h7FFF, 4'b0001};
    vecs[9]  = '{16'h8000, 16'h0100, 2'b00, 16'h8000, 4'b0000};
    vecs[10] = '{16'h0100, 16'h0000, 2'b00, 16'h7FFF, 4'b0100};
    vecs[11] = '{16'hFF00, 16'h0000, 2'b01, 16'h8000, 4'b0100};
    vecs[12] = '{16'h0000, 16'h0000, 2'b00, 16'h0000, 4'b0100};
    vecs[13] = '{16'h0000, 16'h0300, 2'b01, 16'h0000, 4'b0000};
    vecs[14] = '{16'h0100, 16'h0300, 2'b01, 16'h0055, 4'b1000};
    vecs[15] = '{16'h0200, 16'h0300, 2'b01, 16'h00AB, 4'b1000};

    rst_n = 1'b0; start_in = 1'b0; x_in = '0; y_in = '0; round_in = '0;
    #1;
    chk("reset_p", {16'd0, p_out}, 32'd0);
    chk("reset_oor", {28'd0, oor_out}, 32'd0);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_ready", {31'd0, ready_out}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_op($sformatf("v%0d", i), vecs[i].x, vecs[i].y, vecs[i].rnd, vecs[i].p, vecs[i].oor);

    // Extra start pulses during DIV must be ignored.
    v0 = valid_cnt;
    got = 1'b0;
    x_in = 16'h0180; y_in = 16'h0080; round_in = 2'b00; start_in = 1'b1;
    @(posedge clk);
    sb.push_back('{16'h0300, 4'b0000, "dbl"});
    #1 start_in = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k == 3 || k == 12) begin
        x_in = 16'h7F00; y_in = 16'h0040; start_in = 1'b1;
      end
      @(posedge clk); #1;
      start_in = 1'b0;
      if (valid_out === 1'b1) got = 1'b1;
    end
    chk("dbl_got_valid", {31'd0, got}, 32'd1);
    repeat (35) @(posedge clk);
    #1;
    chk("dbl_one_pulse", valid_cnt - v0, 32'd1);

    // Reset mid-operation: outputs clear at once and the aborted op never completes.
    do_op("pre_rst", 16'h0180, 16'h0080, 2'b00, 16'h0300, 4'b0000);
    v0 = valid_cnt;
    x_in = 16'h0100; y_in = 16'h0300; round_in = 2'b00; start_in = 1'b1;
    @(posedge clk);
    #1 start_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_p_zero", {16'd0, p_out}, 32'd0);
    chk("rst_oor_zero", {28'd0, oor_out}, 32'd0);
    chk("rst_valid_low", {31'd0, valid_out}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready_after", {31'd0, ready_out}, 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_valid", valid_cnt - v0, 32'd0);
    do_op("post_rst", 16'h0100, 16'h0300, 2'b10, 16'h0056, 4'b1000);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
